// File: rtl/br_local_injector.sv
// Round-robin injector of N_REQ sources into the BrLite LOCAL port. It stamps seq_source and a rolling id.
// Latency: req rises 2 cycles after valid (IDLE->ARB->SEND). Backpressure: waits in IDLE while local_busy_i is high, and holds req until ack.
module br_local_injector #(
    parameter int          N_REQ       = 4,
    parameter logic [15:0] SEQ_ADDRESS = 16'h0000,
    parameter int          TIMEOUT     = 1024,
    parameter int          ID_W        = 8,
    parameter int          PAYLOAD_W   = 32,
    localparam int         FLIT_W      = PAYLOAD_W + 16 + ID_W,
    localparam int         PTR_W       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int         TCNT_W      = $clog2(TIMEOUT + 1)
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_REQ-1:0]          src_valid_i,
    input  logic [N_REQ*FLIT_W-1:0]   src_flit_i,
    output logic [N_REQ-1:0]          src_ready_o,
    output logic [ID_W-1:0]           src_id_o,
    input  logic                      local_busy_i,
    output logic [FLIT_W-1:0]         rt_flit_o,
    output logic                      rt_req_o,
    input  logic                      rt_ack_i,
    output logic                      timeout_o
);

    // Flit layout: {payload, seq_source[15:0], id}
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] ARB     = 2'd1;
    localparam logic [1:0] SEND    = 2'd2;
    localparam logic [1:0] RELEASE = 2'd3;

    logic [1:0]        state;
    logic [PTR_W-1:0]  rr_ptr;
    logic [PTR_W-1:0]  win_q;
    logic [ID_W-1:0]   id_cnt;
    logic [FLIT_W-1:0] flit_q;
    logic              req_q;
    logic [N_REQ-1:0]  ready_q;
    logic [ID_W-1:0]   src_id_q;
    logic              timeout_q;
    logic [TCNT_W-1:0] tcnt;

    logic [PTR_W-1:0]  win;
    logic              win_vld;
    logic [PTR_W-1:0]  idx;
    int                j;
    logic [FLIT_W-1:0] sel_flit;
    logic [FLIT_W-1:0] stamp;

    // Search starts one past the last winner, so the previous winner is considered last.
    always_comb begin
        win     = rr_ptr;
        win_vld = 1'b0;
        j       = 0;
        idx     = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= N_REQ) begin
                j = j - N_REQ;
            end
            idx = PTR_W'(j);
            if (!win_vld && src_valid_i[idx]) begin
                win_vld = 1'b1;
                win     = idx;
            end
        end
    end

    assign sel_flit = src_flit_i[int'(win)*FLIT_W +: FLIT_W];
    assign stamp    = {sel_flit[FLIT_W-1 -: PAYLOAD_W], SEQ_ADDRESS, id_cnt};

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            rr_ptr    <= PTR_W'(N_REQ - 1);
            win_q     <= '0;
            id_cnt    <= '0;
            flit_q    <= '0;
            req_q     <= 1'b0;
            ready_q   <= '0;
            src_id_q  <= '0;
            timeout_q <= 1'b0;
            tcnt      <= '0;
        end else begin
            ready_q <= '0;
            case (state)
                IDLE: begin
                    if (|src_valid_i && !local_busy_i && !rt_ack_i) begin
                        state <= ARB;
                    end
                end
                ARB: begin
                    if (win_vld) begin
                        rr_ptr <= win;
                        win_q  <= win;
                        flit_q <= stamp;
                        req_q  <= 1'b1;
                        tcnt   <= '0;
                        state  <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (rt_ack_i) begin
                        req_q <= 1'b0;
                        state <= RELEASE;
                    end else if (tcnt != TCNT_W'(TIMEOUT)) begin
                        // A missing ack is only reported; the handshake is never abandoned.
                        tcnt <= tcnt + TCNT_W'(1);
                        if (tcnt == TCNT_W'(TIMEOUT - 1)) begin
                            timeout_q <= 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    if (!rt_ack_i) begin
                        state          <= IDLE;
                        ready_q[win_q] <= 1'b1;
                        src_id_q       <= id_cnt;
                        id_cnt         <= id_cnt + ID_W'(1);
                        timeout_q      <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign rt_req_o    = req_q;
    assign rt_flit_o   = flit_q;
    assign src_ready_o = ready_q;
    assign src_id_o    = src_id_q;
    assign timeout_o   = timeout_q;

endmodule
